// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encoding, captured-access context, and the byte-enable helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_t;

  // What the load extractor needs to remember about an accepted access
  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] ofs;
  } lsu_ctx_t;

  // Byte enables; halfwords look only at ofs[1], words always use all lanes
  function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] ofs);
    case (f3)
      F3_B, F3_BU: be_for = 4'b0001 << ofs;
      F3_H, F3_HU: be_for = ofs[1] ? 4'b1100 : 4'b0011;
      default:     be_for = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load extractor: picks the addressed byte/halfword out of the read word and
// sign- or zero-extends it. Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            ofs,
  input  logic [2:0]            f3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{ofs, 3'b000} +: 8];
  assign h = ofs[1] ? rdata[31:16] : rdata[15:0];

  // Extend the selected lane according to the width/sign code
  always_comb begin
    case (f3)
      F3_B:    data = {{(DATA_WIDTH-8){b[7]}}, b};
      F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, b};
      F3_H:    data = {{(DATA_WIDTH-16){h[15]}}, h};
      F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU effective address plus rs2 store data,
// runs one request/grant/rvalid transaction on the data-memory port and
// returns an extended load result with a one-cycle done pulse.
// Build option: LSU_MISALIGN_TRAP_EN -- misaligned halfword/word accesses
// fault with err instead of silently using the aligned lanes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  lsu_stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  lsu_state_t                   state;
  lsu_ctx_t                     ctx;
  logic [NUM_LANES-1:0][7:0]    wrep;
  logic [DATA_WIDTH-1:0]        ext;
  logic                         f3_legal, misalign, accept, fault;

  // Store data replicated across lanes so any byte enable sees the right value
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wrep[i] = (funct3 == F3_B) ? store_data[7:0] :
                     (funct3 == F3_H) ? store_data[(i%2)*8 +: 8] :
                                        store_data[i*8 +: 8];
  end

  assign f3_legal = (funct3 == F3_B) | (funct3 == F3_H) | (funct3 == F3_W) |
                    (is_load & ((funct3 == F3_BU) | (funct3 == F3_HU)));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
                    ((funct3 == F3_W) & (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept = req_valid & (is_load ^ is_store) & f3_legal & ~misalign;
  assign fault  = req_valid & (is_load | is_store) & ~accept;

  assign lsu_stall = ((state == S_IDLE) & req_valid) | (state == S_REQ) | (state == S_WAIT);

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata (mem_rdata),
    .ofs   (ctx.ofs),
    .f3    (ctx.f3),
    .data  (ext)
  );

  // Transaction FSM; all memory-port and result outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ctx       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            ctx       <= '{f3: funct3, ofs: addr[1:0]};
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= be_for(funct3, addr[1:0]);
            mem_wdata <= wrep;
            state     <= S_REQ;
          end else if (fault) begin
            done      <= 1'b1;
            err       <= 1'b1;
            load_data <= '0;
            state     <= S_RESP;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              done      <= 1'b1;
              load_data <= '0;
              state     <= S_RESP;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            done      <= 1'b1;
            load_data <= ext;
            state     <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus thread drives transactions
// and pushes expected results; a negedge monitor pops on every done pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        lsu_stall, done, err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    string       nm;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .lsu_stall  (lsu_stall),
    .done       (done),
    .load_data  (load_data),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, " load_data"}, load_data, e.data);
        chk({e.nm, " err"}, {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic chk_req(input string nm, input bit ld, input logic [31:0] ea,
                         input logic [3:0] ebe, input logic [31:0] ewd);
    chk({nm, " mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({nm, " mem_we"}, {31'd0, mem_we}, {31'd0, ~ld});
    chk({nm, " mem_addr"}, mem_addr, ea);
    chk({nm, " mem_be"}, {28'd0, mem_be}, {28'd0, ebe});
    if (!ld) chk({nm, " mem_wdata"}, mem_wdata, ewd);
    chk({nm, " stall req"}, {31'd0, lsu_stall}, 32'd1);
  endtask

  // One full transaction; gd = cycles grant is withheld, rd = WAIT cycles before rvalid
  task automatic txn(input string nm, input bit ld, input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd, input int gd, input int rd,
                     input logic [31:0] rdat, input bit spur, input logic [31:0] exp_ld,
                     input bit exp_err, input logic [31:0] ea, input logic [3:0] ebe,
                     input logic [31:0] ewd);
    exp_t e;
    e.nm = nm; e.data = exp_ld; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    #1 chk({nm, " stall idle"}, {31'd0, lsu_stall}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0;
    if (exp_err) begin
      chk({nm, " no mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({nm, " err latency"}, {31'd0, done}, 32'd1);
    end else begin
      for (int i = 0; i < gd; i++) begin
        chk_req(nm, ld, ea, ebe, ewd);
        mem_rvalid = spur && (i == 0);
        mem_rdata  = 32'h11111111;
        @(negedge clk);
      end
      mem_rvalid = 1'b0;
      chk_req(nm, ld, ea, ebe, ewd);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      if (ld) begin
        chk({nm, " wait no req"}, {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < rd; i++) begin
          chk({nm, " stall wait"}, {31'd0, lsu_stall}, 32'd1);
          @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = rdat;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
      chk({nm, " done latency"}, {31'd0, done}, 32'd1);
    end
    chk({nm, " stall resp"}, {31'd0, lsu_stall}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst stall", {31'd0, lsu_stall}, 32'd0);
    rst_n = 1'b1;

    //  name       ld st f3      addr          sdata         gd rd rdata         sp exp_ld        er ea            be     wdata
    txn("sb",      0, 1, 3'b000, 32'h00001003, 32'h000000AB, 0, 0, 32'h0,        0, 32'h00000000, 0, 32'h00001000, 4'h8, 32'hABABABAB);
    txn("lb",      1, 0, 3'b000, 32'h00002002, 32'h0,        0, 2, 32'h12803456, 0, 32'hFFFFFF80, 0, 32'h00002000, 4'h4, 32'h0);
    txn("lbu",     1, 0, 3'b100, 32'h00002002, 32'h0,        0, 2, 32'h12803456, 0, 32'h00000080, 0, 32'h00002000, 4'h4, 32'h0);
    txn("lh",      1, 0, 3'b001, 32'h00002002, 32'h0,        0, 0, 32'h80017FFF, 0, 32'hFFFF8001, 0, 32'h00002000, 4'hC, 32'h0);
    txn("lhu",     1, 0, 3'b101, 32'h00002002, 32'h0,        0, 0, 32'h80017FFF, 0, 32'h00008001, 0, 32'h00002000, 4'hC, 32'h0);
    txn("lw",      1, 0, 3'b010, 32'h00002000, 32'h0,        0, 0, 32'h80017FFF, 0, 32'h80017FFF, 0, 32'h00002000, 4'hF, 32'h0);
    txn("sh",      0, 1, 3'b001, 32'h00001002, 32'h0000BEEF, 1, 0, 32'h0,        0, 32'h00000000, 0, 32'h00001000, 4'hC, 32'hBEEFBEEF);
    txn("lw slow", 1, 0, 3'b010, 32'h00003004, 32'h0,        5, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h00003004, 4'hF, 32'h0);
    txn("sw",      0, 1, 3'b010, 32'h00001004, 32'h12345678, 2, 0, 32'h0,        0, 32'h00000000, 0, 32'h00001004, 4'hF, 32'h12345678);
    txn("lb lane1",1, 0, 3'b000, 32'h00002001, 32'h0,        0, 0, 32'h12803456, 0, 32'h00000034, 0, 32'h00002000, 4'h2, 32'h0);
    txn("ld f3 011",1,0, 3'b011, 32'h00002000, 32'h0,        0, 0, 32'h0,        0, 32'h00000000, 1, 32'h0,        4'h0, 32'h0);
    txn("lw pre",  1, 0, 3'b010, 32'h00002000, 32'h0,        0, 0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 0, 32'h00002000, 4'hF, 32'h0);
    txn("sbu",     0, 1, 3'b100, 32'h00001000, 32'h000000AB, 0, 0, 32'h0,        0, 32'h00000000, 1, 32'h0,        4'h0, 32'h0);
    txn("ld+st",   1, 1, 3'b010, 32'h00001000, 32'h0,        0, 0, 32'h0,        0, 32'h00000000, 1, 32'h0,        4'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn("lw mis",  1, 0, 3'b010, 32'h00002001, 32'h0,        0, 0, 32'h0,        0, 32'h00000000, 1, 32'h0,        4'h0, 32'h0);
    txn("lh mis",  1, 0, 3'b001, 32'h00002003, 32'h0,        0, 0, 32'h0,        0, 32'h00000000, 1, 32'h0,        4'h0, 32'h0);
`else
    txn("lw mis",  1, 0, 3'b010, 32'h00002001, 32'h0,        0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 32'h00002000, 4'hF, 32'h0);
    txn("lh mis",  1, 0, 3'b001, 32'h00002003, 32'h0,        0, 0, 32'h80017FFF, 0, 32'hFFFF8001, 0, 32'h00002000, 4'hC, 32'h0);
`endif

    // Reset while the request is pending: mem_req must drop at once
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h00004000;
    @(negedge clk);
    req_valid = 1'b0; is_load = 1'b0;
    chk("rst-req pre mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst-req mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in WAIT, then a late rvalid that must be discarded
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h00004000;
    @(negedge clk);
    req_valid = 1'b0; is_load = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst-wait pre stall", {31'd0, lsu_stall}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst-wait mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst-wait stall", {31'd0, lsu_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late rvalid done", {31'd0, done}, 32'd0);
    chk("late rvalid load_data", load_data, 32'd0);
    txn("sw post", 0, 1, 3'b010, 32'h00001008, 32'hA5A5C3C3, 0, 0, 32'h0, 0, 32'h00000000, 0, 32'h00001008, 4'hF, 32'hA5A5C3C3);

    repeat (2) @(negedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
